capture_ctrl: RTL and testbench
===============================

CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 12, sample width in bits.
REQ-002 SHALL have parameter ADDR_SIZE, default 8, capture-buffer address width; MEM_SIZE = 2**ADDR_SIZE.
REQ-003 SHALL have parameter CNT_SIZE, default 16, width of timeout and holdoff counters.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports sample_valid_i (input, 1) and sample_i (input, DATA_SIZE): ADC sample stream; a sample is accepted on any cycle with sample_valid_i=1.
REQ-007 SHALL have ports level_i (input, DATA_SIZE), trigger level, and edge_sel_i (input, 1), 0=rising, 1=falling.
REQ-008 SHALL have port mode_i, input, 2: 0=normal, 1=auto, 2=single, 3=treated as normal.
REQ-009 SHALL have ports arm_i (input, 1), start pulse, and abort_i (input, 1), stop pulse.
REQ-010 SHALL have ports auto_timeout_i (input, CNT_SIZE), in accepted samples, and holdoff_i (input, CNT_SIZE), in clock cycles.
REQ-011 SHALL have outputs w_en_o (1), w_addr_o (ADDR_SIZE), w_data_o (DATA_SIZE): buffer write port.
REQ-012 SHALL have outputs trigger_o (1), forced_o (1), capture_done_o (1) as status pulses/flags.
REQ-013 SHALL have outputs rd_valid_o (1), rd_addr_o (ADDR_SIZE), rd_last_o (1) and input rd_ready_i (1): readout handshake; buffer read data is consumed with rd_addr_o.
REQ-014 SHALL have output state_o, 3 bits: IDLE=0, ARMED=1, CAPTURE=2, READOUT=3, HOLDOFF=4.

Function
REQ-015 SHALL leave IDLE for ARMED the cycle after arm_i=1; mode_i latched at that edge and held until return to IDLE.
REQ-016 SHALL, in ARMED, clear the prior-sample-valid flag on entry; the first accepted sample only loads prev and never triggers.
REQ-017 SHALL detect rising trigger when prev < level_i and sample_i >= level_i; falling when prev > level_i and sample_i <= level_i; unsigned compare.
REQ-018 SHALL, in auto mode, count accepted samples in ARMED; when count reaches auto_timeout_i without a trigger, force a trigger on the current sample and set forced_o; auto_timeout_i=0 disables forcing.
REQ-019 SHALL, on trigger (real or forced), pulse trigger_o one cycle, write the triggering sample to address 0, and enter CAPTURE; a real trigger wins if both occur in the same cycle (forced_o=0).
REQ-020 SHALL register all writes: w_en_o=1 exactly one cycle after each accepted sample to be stored, with w_addr_o/w_data_o of that sample.
REQ-021 SHALL, in CAPTURE, write successive accepted samples to addresses 1..MEM_SIZE-1; gaps in sample_valid_i produce no writes and no address advance.
REQ-022 SHALL, on accepting the sample for address MEM_SIZE-1, enter READOUT; capture_done_o pulses coincident with that final w_en_o.
REQ-023 SHALL, in READOUT, hold rd_valid_o=1 with rd_addr_o starting at 0; rd_addr_o increments only on rd_valid_o and rd_ready_i both 1; rd_addr_o stable while stalled.
REQ-024 SHALL assert rd_last_o with rd_valid_o when rd_addr_o=MEM_SIZE-1; that handshake exits READOUT to IDLE (single) or HOLDOFF (normal/auto).
REQ-025 SHALL, in HOLDOFF, wait holdoff_i clock cycles then enter ARMED; holdoff_i=0 enters ARMED next cycle; forced_o clears on entering ARMED.
REQ-026 SHALL, on abort_i=1, enter IDLE next cycle from any state; w_en_o, rd_valid_o, trigger_o deassert; any partial capture is discarded.
REQ-027 SHALL ignore arm_i outside IDLE; abort_i takes priority over arm_i in the same cycle.
REQ-028 SHALL ignore samples in IDLE, READOUT and HOLDOFF.

Reset
REQ-029 SHALL, while rst=1, force state IDLE, all counters and pointers 0, prev-valid 0, and outputs w_en_o, w_addr_o, w_data_o, trigger_o, forced_o, capture_done_o, rd_valid_o, rd_addr_o, rd_last_o, state_o all 0, independent of clk_i.
REQ-030 SHALL resume from IDLE after rst deasserts, requiring a new arm_i; reset mid-capture or mid-readout discards all progress.

Verification
REQ-031 SHALL pass: normal mode, level=0x800, rising, samples 0x700,0x900 -> trigger_o pulse, 0x900 written at addr 0, next 255 samples at 1..255, capture_done_o with final write.
REQ-032 SHALL pass: falling edge, samples 0x900,0x800 -> trigger; samples 0x800,0x800 -> no trigger.
REQ-033 SHALL pass: auto mode, auto_timeout=10, flat signal -> forced trigger on 10th accepted sample, forced_o=1 through readout.
REQ-034 SHALL pass: readout with rd_ready_i toggling every other cycle -> addresses 0..255 each presented once, rd_last_o only at 255; single mode then IDLE.
REQ-035 SHALL pass: abort_i at capture address 100 -> IDLE next cycle, no further writes; re-arm restarts at address 0.
REQ-036 SHALL pass: rst asserted mid-READOUT -> all outputs 0 immediately, state_o=0 without a clock edge.

Source files
------------

// File: rtl/capture_ctrl.sv
// -----------------------------------------------------------------------------
// capture_ctrl
//
// Triggered capture controller for an ADC sample stream.
//
// Once armed, it watches accepted samples for a level crossing (rising or
// falling, unsigned compare against level_i). In auto mode it can also force
// a trigger after a number of accepted samples. The triggering sample goes to
// buffer address 0, and the following samples fill addresses 1..MEM_SIZE-1.
// The buffer is then presented for readout with a valid/ready handshake.
// After readout the block returns to IDLE (single mode) or waits out a
// holdoff period and re-arms (normal/auto mode).
//
// Ports
//   clk_i           : clock, rising edge
//   rst             : asynchronous active-high reset
//   sample_valid_i  : sample strobe; a sample is accepted whenever this is 1
//   sample_i        : sample value
//   level_i         : trigger level
//   edge_sel_i      : 0 = rising crossing, 1 = falling crossing
//   mode_i          : 0 = normal, 1 = auto, 2 = single, 3 = normal
//   arm_i           : start pulse (only honoured in IDLE)
//   abort_i         : stop pulse (any state, wins over arm_i)
//   auto_timeout_i  : accepted samples before a forced trigger (0 = never)
//   holdoff_i       : clock cycles spent in HOLDOFF before re-arming
//   w_en_o/w_addr_o/w_data_o : registered buffer write port
//   trigger_o       : one-cycle pulse alongside the address-0 write
//   forced_o        : current capture was started by the auto timeout
//   capture_done_o  : pulse alongside the final buffer write
//   rd_valid_o/rd_addr_o/rd_last_o/rd_ready_i : readout handshake
//   state_o         : IDLE=0, ARMED=1, CAPTURE=2, READOUT=3, HOLDOFF=4
// -----------------------------------------------------------------------------
module capture_ctrl #(
    parameter int DATA_SIZE = 12,
    parameter int ADDR_SIZE = 8,
    parameter int CNT_SIZE  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic                 sample_valid_i,
    input  logic [DATA_SIZE-1:0] sample_i,
    input  logic [DATA_SIZE-1:0] level_i,
    input  logic                 edge_sel_i,
    input  logic [1:0]           mode_i,
    input  logic                 arm_i,
    input  logic                 abort_i,
    input  logic [CNT_SIZE-1:0]  auto_timeout_i,
    input  logic [CNT_SIZE-1:0]  holdoff_i,
    output logic                 w_en_o,
    output logic [ADDR_SIZE-1:0] w_addr_o,
    output logic [DATA_SIZE-1:0] w_data_o,
    output logic                 trigger_o,
    output logic                 forced_o,
    output logic                 capture_done_o,
    output logic                 rd_valid_o,
    output logic [ADDR_SIZE-1:0] rd_addr_o,
    output logic                 rd_last_o,
    input  logic                 rd_ready_i,
    output logic [2:0]           state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_READOUT = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_t;

    localparam logic [ADDR_SIZE-1:0] ADDR_LAST = '1;
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE  = ADDR_SIZE'(1);
    localparam logic [CNT_SIZE-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_SIZE-1:0]  CNT_ONE   = CNT_SIZE'(1);
    localparam logic [CNT_SIZE:0]    HOLD_ONE  = (CNT_SIZE+1)'(1);

    state_t                 state_q, state_d;
    logic [1:0]             mode_q, mode_d;
    logic [DATA_SIZE-1:0]   prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [CNT_SIZE-1:0]    auto_cnt_q, auto_cnt_d;
    logic [CNT_SIZE-1:0]    hold_cnt_q, hold_cnt_d;
    logic [ADDR_SIZE-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
    logic                   w_en_q, w_en_d;
    logic [ADDR_SIZE-1:0]   w_addr_q, w_addr_d;
    logic [DATA_SIZE-1:0]   w_data_q, w_data_d;
    logic                   trigger_q, trigger_d;
    logic                   forced_q, forced_d;
    logic                   done_q, done_d;

    logic                   is_auto;
    logic                   is_single;
    logic                   rise_hit;
    logic                   fall_hit;
    logic                   real_trig;
    logic                   force_trig;
    logic [CNT_SIZE-1:0]    auto_cnt_inc;
    logic [CNT_SIZE:0]      hold_cnt_inc;

    assign is_auto   = (mode_q == 2'd1);
    assign is_single = (mode_q == 2'd2);

    // Crossing detection against the previous accepted sample. A crossing is
    // only meaningful once a previous sample exists in this armed period.
    assign rise_hit  = (prev_q < level_i) && (sample_i >= level_i);
    assign fall_hit  = (prev_q > level_i) && (sample_i <= level_i);
    assign real_trig = sample_valid_i && prev_valid_q && (edge_sel_i ? fall_hit : rise_hit);

    // The count includes the current sample, so a timeout of N forces on the
    // Nth accepted sample. A real crossing in the same cycle takes precedence.
    assign auto_cnt_inc = auto_cnt_q + CNT_ONE;
    assign force_trig   = is_auto && sample_valid_i && (auto_timeout_i != CNT_ZERO)
                          && (auto_cnt_inc == auto_timeout_i) && !real_trig;

    // One bit wider so a holdoff of all-ones cannot wrap the comparison.
    // HOLDOFF lasts holdoff_i cycles, with a minimum of one.
    assign hold_cnt_inc = {1'b0, hold_cnt_q} + HOLD_ONE;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mode_q       <= 2'd0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            auto_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            wr_ptr_q     <= '0;
            rd_addr_q    <= '0;
            w_en_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            trigger_q    <= 1'b0;
            forced_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            auto_cnt_q   <= auto_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_addr_q    <= rd_addr_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            trigger_q    <= trigger_d;
            forced_q     <= forced_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        auto_cnt_d   = auto_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_addr_d    = rd_addr_q;
        w_en_d       = 1'b0;
        w_addr_d     = w_addr_q;
        w_data_d     = w_data_q;
        trigger_d    = 1'b0;
        forced_d     = forced_q;
        done_d       = 1'b0;

        if (abort_i) begin
            // Partial progress is dropped; the next arm starts from scratch.
            state_d  = ST_IDLE;
            forced_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (arm_i) begin
                        state_d      = ST_ARMED;
                        mode_d       = mode_i;
                        prev_valid_d = 1'b0;
                        auto_cnt_d   = '0;
                        forced_d     = 1'b0;
                    end
                end

                ST_ARMED: begin
                    if (sample_valid_i) begin
                        prev_d       = sample_i;
                        prev_valid_d = 1'b1;
                        auto_cnt_d   = auto_cnt_inc;
                        if (real_trig || force_trig) begin
                            state_d   = ST_CAPTURE;
                            trigger_d = 1'b1;
                            forced_d  = force_trig;
                            w_en_d    = 1'b1;
                            w_addr_d  = '0;
                            w_data_d  = sample_i;
                            wr_ptr_d  = ADDR_ONE;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (sample_valid_i) begin
                        w_en_d   = 1'b1;
                        w_addr_d = wr_ptr_q;
                        w_data_d = sample_i;
                        if (wr_ptr_q == ADDR_LAST) begin
                            state_d   = ST_READOUT;
                            done_d    = 1'b1;
                            rd_addr_d = '0;
                        end else begin
                            wr_ptr_d = wr_ptr_q + ADDR_ONE;
                        end
                    end
                end

                ST_READOUT: begin
                    if (rd_ready_i) begin
                        if (rd_addr_q == ADDR_LAST) begin
                            state_d    = is_single ? ST_IDLE : ST_HOLDOFF;
                            hold_cnt_d = '0;
                        end else begin
                            rd_addr_d = rd_addr_q + ADDR_ONE;
                        end
                    end
                end

                ST_HOLDOFF: begin
                    if (hold_cnt_inc >= {1'b0, holdoff_i}) begin
                        state_d      = ST_ARMED;
                        prev_valid_d = 1'b0;
                        auto_cnt_d   = '0;
                        forced_d     = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_inc[CNT_SIZE-1:0];
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign w_en_o         = w_en_q;
    assign w_addr_o       = w_addr_q;
    assign w_data_o       = w_data_q;
    assign trigger_o      = trigger_q;
    assign forced_o       = forced_q;
    assign capture_done_o = done_q;
    assign state_o        = state_q;

    // Readout flags decode straight from registered state, so reset clears
    // them without waiting for a clock edge.
    assign rd_valid_o     = (state_q == ST_READOUT);
    assign rd_addr_o      = rd_addr_q;
    assign rd_last_o      = rd_valid_o && (rd_addr_q == ADDR_LAST);

endmodule

// File: tb/tb_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_capture_ctrl
//
// Directed bench for capture_ctrl with default parameters (12-bit samples,
// 256-entry buffer). Inputs change on the falling clock edge; outputs are
// checked on the following falling edge, so each check sees the effect of
// exactly one rising edge.
// -----------------------------------------------------------------------------
module tb_capture_ctrl;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        sample_valid_i;
    logic [11:0] sample_i;
    logic [11:0] level_i;
    logic        edge_sel_i;
    logic [1:0]  mode_i;
    logic        arm_i;
    logic        abort_i;
    logic [15:0] auto_timeout_i;
    logic [15:0] holdoff_i;
    logic        w_en_o;
    logic [7:0]  w_addr_o;
    logic [11:0] w_data_o;
    logic        trigger_o;
    logic        forced_o;
    logic        capture_done_o;
    logic        rd_valid_o;
    logic [7:0]  rd_addr_o;
    logic        rd_last_o;
    logic        rd_ready_i;
    logic [2:0]  state_o;

    int total = 0;
    int bad   = 0;

    capture_ctrl #(.DATA_SIZE(12), .ADDR_SIZE(8), .CNT_SIZE(16)) dut (
        .clk_i          (clk_i),
        .rst            (rst),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .level_i        (level_i),
        .edge_sel_i     (edge_sel_i),
        .mode_i         (mode_i),
        .arm_i          (arm_i),
        .abort_i        (abort_i),
        .auto_timeout_i (auto_timeout_i),
        .holdoff_i      (holdoff_i),
        .w_en_o         (w_en_o),
        .w_addr_o       (w_addr_o),
        .w_data_o       (w_data_o),
        .trigger_o      (trigger_o),
        .forced_o       (forced_o),
        .capture_done_o (capture_done_o),
        .rd_valid_o     (rd_valid_o),
        .rd_addr_o      (rd_addr_o),
        .rd_last_o      (rd_last_o),
        .rd_ready_i     (rd_ready_i),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_sample(input logic v, input logic [11:0] d);
        sample_valid_i = v;
        sample_i       = d;
        @(negedge clk_i);
    endtask

    task automatic pulse_arm();
        arm_i = 1'b1;
        @(negedge clk_i);
        arm_i = 1'b0;
    endtask

    task automatic pulse_abort();
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
    endtask

    // Feeds samples for addresses 1..255 back to back.
    task automatic fill_capture();
        for (int i = 1; i < 256; i++) drive_sample(1'b1, 12'(i));
        sample_valid_i = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk_i);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", state_o); end
        total++; if ({w_en_o, trigger_o, forced_o, capture_done_o, rd_valid_o, rd_last_o} !== 6'b0)
            begin bad++; $display("FAIL rst_flags: got %b want 000000", {w_en_o, trigger_o, forced_o, capture_done_o, rd_valid_o, rd_last_o}); end
        total++; if ({w_addr_o, w_data_o, rd_addr_o} !== 28'h0) begin bad++; $display("FAIL rst_buses: got %h want 0", {w_addr_o, w_data_o, rd_addr_o}); end
        rst = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rst_release_idle: got %0d want 0", state_o); end
    endtask

    task automatic test_normal_rising();
        mode_i = 2'd0; edge_sel_i = 1'b0; level_i = 12'h800; holdoff_i = 16'd0; auto_timeout_i = 16'd0;
        pulse_arm();
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL norm_armed: got %0d want 1", state_o); end
        // first sample above level must only load prev (prev register is 0 after reset)
        drive_sample(1'b1, 12'h900);
        total++; if (trigger_o !== 1'b0 || w_en_o !== 1'b0) begin bad++; $display("FAIL norm_first_sample: got trig=%b wen=%b want 0 0", trigger_o, w_en_o); end
        drive_sample(1'b1, 12'h700);
        total++; if (trigger_o !== 1'b0) begin bad++; $display("FAIL norm_below: got %b want 0", trigger_o); end
        drive_sample(1'b1, 12'h900);
        total++; if ({trigger_o, w_en_o, forced_o} !== 3'b110) begin bad++; $display("FAIL norm_trig_flags: got %b want 110", {trigger_o, w_en_o, forced_o}); end
        total++; if (w_addr_o !== 8'd0 || w_data_o !== 12'h900) begin bad++; $display("FAIL norm_trig_write: got a=%0d d=%h want a=0 d=900", w_addr_o, w_data_o); end
        total++; if (state_o !== 3'd2) begin bad++; $display("FAIL norm_capture_state: got %0d want 2", state_o); end
        for (int i = 1; i < 256; i++) begin
            if (i % 8 == 0) begin
                drive_sample(1'b0, 12'hfff);
                total++; if (w_en_o !== 1'b0) begin bad++; $display("FAIL norm_gap_%0d: got wen=%b want 0", i, w_en_o); end
            end
            drive_sample(1'b1, 12'(i * 3));
            total++; if (w_en_o !== 1'b1 || w_addr_o !== 8'(i) || w_data_o !== 12'(i * 3) || trigger_o !== 1'b0)
                begin bad++; $display("FAIL norm_write_%0d: got wen=%b a=%0d d=%h trig=%b want 1 %0d %h 0", i, w_en_o, w_addr_o, w_data_o, trigger_o, i, 12'(i * 3)); end
            total++; if (capture_done_o !== (i == 255)) begin bad++; $display("FAIL norm_done_%0d: got %b want %b", i, capture_done_o, (i == 255)); end
        end
        sample_valid_i = 1'b0;
        total++; if (state_o !== 3'd3) begin bad++; $display("FAIL norm_readout_state: got %0d want 3", state_o); end
        for (int k = 0; k < 256; k++) begin
            total++; if (rd_valid_o !== 1'b1 || rd_addr_o !== 8'(k) || rd_last_o !== (k == 255))
                begin bad++; $display("FAIL norm_rd_%0d: got v=%b a=%0d l=%b want 1 %0d %b", k, rd_valid_o, rd_addr_o, rd_last_o, k, (k == 255)); end
            rd_ready_i = 1'b1;
            @(negedge clk_i);
        end
        rd_ready_i = 1'b0;
        total++; if (state_o !== 3'd4 || rd_valid_o !== 1'b0) begin bad++; $display("FAIL norm_holdoff: got st=%0d v=%b want 4 0", state_o, rd_valid_o); end
        @(negedge clk_i);
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL norm_rearm: got %0d want 1", state_o); end
        pulse_abort();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL norm_abort: got %0d want 0", state_o); end
    endtask

    task automatic test_falling();
        mode_i = 2'd0; edge_sel_i = 1'b1; level_i = 12'h800;
        pulse_arm();
        drive_sample(1'b1, 12'h800);
        drive_sample(1'b1, 12'h800);
        total++; if (trigger_o !== 1'b0) begin bad++; $display("FAIL fall_flat_equal: got %b want 0", trigger_o); end
        drive_sample(1'b1, 12'h900);
        total++; if (trigger_o !== 1'b0) begin bad++; $display("FAIL fall_rise_ignored: got %b want 0", trigger_o); end
        drive_sample(1'b1, 12'h800);
        total++; if (trigger_o !== 1'b1 || w_data_o !== 12'h800 || w_addr_o !== 8'd0)
            begin bad++; $display("FAIL fall_trig: got t=%b d=%h a=%0d want 1 800 0", trigger_o, w_data_o, w_addr_o); end
        sample_valid_i = 1'b0;
        pulse_abort();
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL fall_abort: got %0d want 0", state_o); end
    endtask

    task automatic test_auto();
        mode_i = 2'd1; edge_sel_i = 1'b0; level_i = 12'h800; auto_timeout_i = 16'd10; holdoff_i = 16'd3;
        pulse_arm();
        for (int i = 1; i <= 9; i++) begin
            drive_sample(1'b1, 12'h400);
            total++; if (trigger_o !== 1'b0) begin bad++; $display("FAIL auto_early_%0d: got %b want 0", i, trigger_o); end
        end
        drive_sample(1'b1, 12'h400);
        total++; if ({trigger_o, forced_o, w_en_o} !== 3'b111 || w_data_o !== 12'h400 || w_addr_o !== 8'd0)
            begin bad++; $display("FAIL auto_force: got tfw=%b d=%h a=%0d want 111 400 0", {trigger_o, forced_o, w_en_o}, w_data_o, w_addr_o); end
        fill_capture();
        total++; if (capture_done_o !== 1'b1 || forced_o !== 1'b1 || state_o !== 3'd3)
            begin bad++; $display("FAIL auto_done: got d=%b f=%b st=%0d want 1 1 3", capture_done_o, forced_o, state_o); end
        for (int k = 0; k < 256; k++) begin
            total++; if (forced_o !== 1'b1 || rd_addr_o !== 8'(k)) begin bad++; $display("FAIL auto_rd_%0d: got f=%b a=%0d want 1 %0d", k, forced_o, rd_addr_o, k); end
            rd_ready_i = 1'b1;
            @(negedge clk_i);
        end
        rd_ready_i = 1'b0;
        for (int h = 0; h < 3; h++) begin
            total++; if (state_o !== 3'd4) begin bad++; $display("FAIL auto_holdoff_%0d: got %0d want 4", h, state_o); end
            @(negedge clk_i);
        end
        total++; if (state_o !== 3'd1 || forced_o !== 1'b0) begin bad++; $display("FAIL auto_rearm: got st=%0d f=%b want 1 0", state_o, forced_o); end
        pulse_abort();
        auto_timeout_i = 16'd0; holdoff_i = 16'd0;
    endtask

    task automatic test_readout_stall_single();
        int exp_addr;
        int cyc;
        mode_i = 2'd2; edge_sel_i = 1'b0; level_i = 12'h800;
        pulse_arm();
        drive_sample(1'b1, 12'h100);
        drive_sample(1'b1, 12'h900);
        total++; if (trigger_o !== 1'b1) begin bad++; $display("FAIL single_trig: got %b want 1", trigger_o); end
        fill_capture();
        exp_addr = 0;
        cyc = 0;
        while (exp_addr <= 255 && cyc < 2000) begin
            total++; if (rd_valid_o !== 1'b1 || rd_addr_o !== 8'(exp_addr) || rd_last_o !== (exp_addr == 255))
                begin bad++; $display("FAIL stall_rd_c%0d: got v=%b a=%0d l=%b want 1 %0d %b", cyc, rd_valid_o, rd_addr_o, rd_last_o, exp_addr, (exp_addr == 255)); end
            rd_ready_i = cyc[0];
            @(negedge clk_i);
            if (rd_ready_i) exp_addr++;
            cyc++;
        end
        rd_ready_i = 1'b0;
        total++; if (exp_addr != 256) begin bad++; $display("FAIL stall_budget: got %0d addresses want 256", exp_addr); end
        total++; if (state_o !== 3'd0 || rd_valid_o !== 1'b0) begin bad++; $display("FAIL single_idle: got st=%0d v=%b want 0 0", state_o, rd_valid_o); end
    endtask

    task automatic test_abort();
        mode_i = 2'd0; edge_sel_i = 1'b0; level_i = 12'h800;
        pulse_arm();
        drive_sample(1'b1, 12'h700);
        drive_sample(1'b1, 12'h900);
        for (int i = 1; i <= 100; i++) begin
            arm_i = (i == 50);
            drive_sample(1'b1, 12'(i + 12'h200));
            total++; if (w_en_o !== 1'b1 || w_addr_o !== 8'(i)) begin bad++; $display("FAIL abort_fill_%0d: got wen=%b a=%0d want 1 %0d", i, w_en_o, w_addr_o, i); end
        end
        arm_i = 1'b0;
        abort_i = 1'b1;
        drive_sample(1'b1, 12'h555);
        abort_i = 1'b0;
        total++; if (state_o !== 3'd0 || w_en_o !== 1'b0 || trigger_o !== 1'b0)
            begin bad++; $display("FAIL abort_idle: got st=%0d wen=%b t=%b want 0 0 0", state_o, w_en_o, trigger_o); end
        for (int i = 0; i < 3; i++) begin
            drive_sample(1'b1, 12'h900);
            total++; if (w_en_o !== 1'b0) begin bad++; $display("FAIL abort_nowrite_%0d: got %b want 0", i, w_en_o); end
        end
        sample_valid_i = 1'b0;
        pulse_arm();
        drive_sample(1'b1, 12'h700);
        drive_sample(1'b1, 12'h900);
        total++; if (trigger_o !== 1'b1 || w_addr_o !== 8'd0) begin bad++; $display("FAIL abort_restart: got t=%b a=%0d want 1 0", trigger_o, w_addr_o); end
        drive_sample(1'b1, 12'h123);
        total++; if (w_addr_o !== 8'd1 || w_data_o !== 12'h123) begin bad++; $display("FAIL abort_restart_next: got a=%0d d=%h want 1 123", w_addr_o, w_data_o); end
        sample_valid_i = 1'b0;
        pulse_abort();
    endtask

    task automatic test_reset_readout();
        mode_i = 2'd0; edge_sel_i = 1'b0; level_i = 12'h800;
        pulse_arm();
        drive_sample(1'b1, 12'h700);
        drive_sample(1'b1, 12'h900);
        fill_capture();
        rd_ready_i = 1'b1;
        repeat (5) @(negedge clk_i);
        rd_ready_i = 1'b0;
        total++; if (rd_addr_o !== 8'd5 || state_o !== 3'd3) begin bad++; $display("FAIL rr_pre: got a=%0d st=%0d want 5 3", rd_addr_o, state_o); end
        #2 rst = 1'b1;
        #1;
        total++; if (state_o !== 3'd0 || rd_valid_o !== 1'b0 || rd_last_o !== 1'b0 || rd_addr_o !== 8'd0)
            begin bad++; $display("FAIL rr_async_rd: got st=%0d v=%b l=%b a=%0d want 0 0 0 0", state_o, rd_valid_o, rd_last_o, rd_addr_o); end
        total++; if ({w_en_o, trigger_o, forced_o, capture_done_o} !== 4'b0 || w_addr_o !== 8'd0 || w_data_o !== 12'd0)
            begin bad++; $display("FAIL rr_async_wr: got f=%b a=%0d d=%h want 0000 0 0", {w_en_o, trigger_o, forced_o, capture_done_o}, w_addr_o, w_data_o); end
        @(negedge clk_i);
        rst = 1'b0;
        @(negedge clk_i);
        total++; if (state_o !== 3'd0) begin bad++; $display("FAIL rr_stay_idle: got %0d want 0", state_o); end
        pulse_arm();
        total++; if (state_o !== 3'd1) begin bad++; $display("FAIL rr_rearm: got %0d want 1", state_o); end
        pulse_abort();
    endtask

    initial begin
        rst = 1'b1;
        sample_valid_i = 1'b0; sample_i = '0; level_i = 12'h800; edge_sel_i = 1'b0;
        mode_i = 2'd0; arm_i = 1'b0; abort_i = 1'b0; auto_timeout_i = '0; holdoff_i = '0;
        rd_ready_i = 1'b0;
        @(negedge clk_i);
        test_reset();
        test_normal_rising();
        test_falling();
        test_auto();
        test_readout_stall_single();
        test_abort();
        test_reset_readout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
